leb128_decoder: RTL and testbench

Immediate-operand decoder sitting between the byte fetch path (ROM window, genrom data/error) and the CPU execute stage. Accepts a decode command (signed/unsigned, 32/64-bit), consumes a LEB128 byte stream one byte per cycle via valid/ready, and returns the decoded immediate with its byte length or a trap code. Feeds i32.const/i64.const, branch depths, local indices and memarg fields to the CPU.

---
 rtl/leb128_decoder.sv | 140 ++++++++++++++
 tb/tb_leb128_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_decoder.sv
`default_nettype none
// ============================================================================
// Module   : leb128_decoder
// Brief    : Decodes one signed/unsigned, 32/64-bit LEB128 immediate from a
//            byte stream (one byte per cycle) into a 64-bit value, its byte
//            length, or a trap code (too long / too large / fetch error).
// Revision : 1.0 - initial release
// ============================================================================
module leb128_decoder #(
    parameter int VALUE_W = 64,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_signed,
    input  logic               cmd_is64,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic [7:0]         byte_data,
    input  logic               byte_error,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [VALUE_W-1:0] res_value,
    output logic [LEN_W-1:0]   res_len,
    output logic [1:0]         res_trap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] TRAP_NONE  = 2'd0;
    localparam logic [1:0] TRAP_LONG  = 2'd1;
    localparam logic [1:0] TRAP_LARGE = 2'd2;
    localparam logic [1:0] TRAP_FETCH = 2'd3;

    logic [1:0]         state;
    logic               is_signed;
    logic               is64;
    logic [VALUE_W-1:0] acc;
    logic [LEN_W-1:0]   count;

    logic [6:0]         shift;
    logic [6:0]         term_shift;
    logic [VALUE_W-1:0] acc_next;
    logic [VALUE_W-1:0] extended;
    logic [VALUE_W-1:0] final_value;
    logic               is_last;
    logic               range_bad;
    logic [LEN_W-1:0]   len_next;

    assign cmd_ready  = (state == IDLE);
    assign byte_ready = (state == ACCUM);
    assign res_valid  = (state == DONE);

    // Accumulate the incoming group, check the final-byte range and build the
    // sign/zero-extended result the terminator would produce.
    always_comb begin
        shift       = 7'({3'd0, count} * 7'd7);
        term_shift  = shift + 7'd7;
        acc_next    = acc | ({57'd0, byte_data[6:0]} << shift);
        len_next    = count + LEN_W'(1);
        is_last     = is64 ? (count == LEN_W'(9)) : (count == LEN_W'(4));
        range_bad   = 1'b0;
        case ({is_signed, is64})
            2'b00:   range_bad = (byte_data[6:4] != 3'b000);
            2'b10:   range_bad = (byte_data[6:3] != 4'b0000) && (byte_data[6:3] != 4'b1111);
            2'b01:   range_bad = (byte_data[6:1] != 6'd0);
            default: range_bad = (byte_data[6:0] != 7'h00) && (byte_data[6:0] != 7'h7F);
        endcase
        extended = acc_next;
        if (is_signed && byte_data[6] && (term_shift < 7'd64)) begin
            extended = acc_next | (~64'd0 << term_shift);
        end
        final_value = extended;
        if (!is64) begin
            final_value = is_signed ? {{32{extended[31]}}, extended[31:0]}
                                    : {32'd0, extended[31:0]};
        end
    end

    // Command/byte/result sequencing and the registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            is_signed <= 1'b0;
            is64      <= 1'b0;
            acc       <= '0;
            count     <= '0;
            res_value <= '0;
            res_len   <= '0;
            res_trap  <= TRAP_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_signed <= cmd_signed;
                        is64      <= cmd_is64;
                        acc       <= '0;
                        count     <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (byte_valid) begin
                        if (byte_error) begin
                            res_trap  <= TRAP_FETCH;
                            res_value <= '0;
                            res_len   <= len_next;
                            state     <= DONE;
                        end else if (is_last && (byte_data[7] || range_bad)) begin
                            res_trap  <= byte_data[7] ? TRAP_LONG : TRAP_LARGE;
                            res_value <= '0;
                            res_len   <= len_next;
                            state     <= DONE;
                        end else if (!byte_data[7]) begin
                            res_trap  <= TRAP_NONE;
                            res_value <= final_value;
                            res_len   <= len_next;
                            state     <= DONE;
                        end else begin
                            acc   <= acc_next;
                            count <= len_next;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leb128_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_leb128_decoder
// Brief    : Directed scoreboard bench for leb128_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leb128_decoder;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_signed;
    logic        cmd_is64;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_error;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_value;
    logic [3:0]  res_len;
    logic [1:0]  res_trap;

    typedef struct {
        logic [63:0] value;
        logic [3:0]  len;
        logic [1:0]  trap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    leb128_decoder #(.VALUE_W(64), .LEN_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_signed (cmd_signed),
        .cmd_is64   (cmd_is64),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_error (byte_error),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_len    (res_len),
        .res_trap   (res_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] v, input logic [3:0] l, input logic [1:0] t);
        exp_t e;
        e.value = v;
        e.len   = l;
        e.trap  = t;
        sb.push_back(e);
    endtask

    // All driver tasks start and end just after a falling edge.
    task automatic send_cmd(input logic s, input logic w64);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_signed = s;
        cmd_is64   = w64;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic err);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_error = err;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check("byte_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_error = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        int   n = 0;
        exp_t e;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_value"}, res_value, e.value);
        check({tag, "_len"}, 64'(res_len), 64'(e.len));
        check({tag, "_trap"}, 64'(res_trap), 64'(e.trap));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_value"}, res_value, e.value);
            check({tag, "_hold_len"}, 64'(res_len), 64'(e.len));
            check({tag, "_hold_bready"}, 64'(byte_ready), 64'd0);
            check({tag, "_hold_cready"}, 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle"}, 64'(cmd_ready), 64'd1);
        check({tag, "_released"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_signed = 1'b0;
        cmd_is64   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_error = 1'b0;
        res_ready  = 1'b0;
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        check("rst_value", res_value, 64'd0);
        check("rst_len", 64'(res_len), 64'd0);
        check("rst_trap", 64'(res_trap), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // u32 E5 8E 26 back-to-back; result one cycle after last byte
        push_exp(64'h0000_0000_0009_8765, 4'd3, 2'd0);
        send_cmd(1'b0, 1'b0);
        send_byte(8'hE5, 1'b0);
        send_byte(8'h8E, 1'b0);
        check("u32_mid_valid", 64'(res_valid), 64'd0);
        send_byte(8'h26, 1'b0);
        check("u32_latency", 64'(res_valid), 64'd1);
        collect("u32_624485", 0);

        // s64 C0 BB 78 = -123456
        push_exp(64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0);
        send_cmd(1'b1, 1'b1);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h78, 1'b0);
        collect("s64_neg", 0);

        // s32 7F = -1, minimum 2-cycle command-to-result
        push_exp(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0);
        send_cmd(1'b1, 1'b0);
        send_byte(8'h7F, 1'b0);
        check("s32_latency", 64'(res_valid), 64'd1);
        collect("s32_m1", 0);

        // u32 five-byte maximum and its trap variants
        push_exp(64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0);
        send_cmd(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h0F, 1'b0);
        collect("u32_max", 0);

        push_exp(64'd0, 4'd5, 2'd2);
        send_cmd(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h1F, 1'b0);
        collect("u32_large", 0);

        push_exp(64'd0, 4'd5, 2'd1);
        send_cmd(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h8F, 1'b0);
        collect("u32_long", 0);

        // s32 last byte out of range
        push_exp(64'd0, 4'd5, 2'd2);
        send_cmd(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h4F, 1'b0);
        collect("s32_large", 0);

        // u64 ten-byte maximum, then last-byte overflow
        push_exp(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0);
        send_cmd(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        collect("u64_max", 0);

        push_exp(64'd0, 4'd10, 2'd2);
        send_cmd(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h02, 1'b0);
        collect("u64_large", 0);

        // s64 most negative value: 80 x9, 7F
        push_exp(64'h8000_0000_0000_0000, 4'd10, 2'd0);
        send_cmd(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'h80, 1'b0);
        send_byte(8'h7F, 1'b0);
        collect("s64_min", 0);

        // fetch error on second byte
        push_exp(64'd0, 4'd2, 2'd3);
        send_cmd(1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h55, 1'b1);
        collect("u32_fetch_err", 0);

        // u64 with byte gaps and 4 cycles of result backpressure; stray
        // byte_valid during the hold must not be consumed
        push_exp(64'h0000_0000_0009_8765, 4'd3, 2'd0);
        send_cmd(1'b0, 1'b1);
        send_byte(8'hE5, 1'b0);
        repeat (2) @(negedge clk);
        send_byte(8'h8E, 1'b0);
        @(negedge clk);
        send_byte(8'h26, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        collect("u64_hold", 4);
        byte_valid = 1'b0;

        // reset mid-ACCUM after two bytes discards the partial decode
        send_cmd(1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h80, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_byte_ready", 64'(byte_ready), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_value", res_value, 64'd0);
        check("midrst_len", 64'(res_len), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        push_exp(64'd5, 4'd1, 2'd0);
        send_cmd(1'b0, 1'b0);
        send_byte(8'h05, 1'b0);
        collect("post_rst_u32", 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
